// File: rtl/insmem_pkg.sv
// ----------------------------------------------------------------------------
// insmem_pkg
// Shared definitions for the instruction fetch memory:
//   insmem_state_e    - LOAD (memory being filled) / RUN (fetches served)
//   NOP_WORD_DEFAULT  - default word returned for faulted fetches
// Optional feature macro used by the design files: INSMEM_PARITY_EN
// ----------------------------------------------------------------------------
package insmem_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } insmem_state_e;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_mem_if.sv
// ----------------------------------------------------------------------------
// instr_fetch_mem_if
// Bundles the loader, fetch-request and fetch-response signals of
// instr_fetch_mem.
//   master : drives loader, request, flush and resp_ready (CPU/loader side)
//   slave  : drives req_ready, resp_* and loaded (memory side)
// Handshake rules: a request transfers on a rising edge where
// req_valid && req_ready; a response transfers on a rising edge where
// resp_valid && resp_ready. A held response (resp_valid && !resp_ready) keeps
// all resp_* values unchanged. flush drops any held response and blocks
// acceptance in the same cycle.
// ----------------------------------------------------------------------------
interface instr_fetch_mem_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [WIDTH-1:0]  ld_data;
    logic              ld_last;

    logic              req_valid;
    logic [31:0]       req_pc;
    logic              req_ready;
    logic              flush;

    logic              resp_valid;
    logic              resp_ready;
    logic [WIDTH-1:0]  resp_instr;
    logic              resp_fault;
    logic              resp_perr;

    logic              loaded;

    modport master (
        output ld_valid, ld_addr, ld_data, ld_last,
        output req_valid, req_pc, flush, resp_ready,
        input  req_ready, resp_valid, resp_instr, resp_fault, resp_perr, loaded
    );

    modport slave (
        input  ld_valid, ld_addr, ld_data, ld_last,
        input  req_valid, req_pc, flush, resp_ready,
        output req_ready, resp_valid, resp_instr, resp_fault, resp_perr, loaded
    );

endinterface

// File: rtl/insmem_array.sv
// ----------------------------------------------------------------------------
// insmem_array
// Single-port-write / single-port-read storage with synchronous write and
// synchronous (registered) read.
//   clk, rst : clock; rst clears only the read register, never the storage
//   we/waddr/wdata : write port
//   re/raddr       : read enable / address; rdata updates only when re=1,
//                    otherwise it holds the last word read
// ----------------------------------------------------------------------------
module insmem_array #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    // Storage has no reset so contents survive a reset in the middle of a load.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Holding the read register when re=0 keeps a stalled response stable.
    always_comb begin
        rd_data_d = rd_data_q;
        if (re) begin
            rd_data_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rdata = rd_data_q;

endmodule

// File: rtl/instr_fetch_mem.sv
// ----------------------------------------------------------------------------
// instr_fetch_mem
// Instruction memory filled by a loader in LOAD state, then serving fetches
// with one-cycle latency and full throughput in RUN state.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : instr_fetch_mem_if.slave (loader, request, response, loaded)
//   dbg_state  : current FSM state for observation
// Parameters: WIDTH (word bits), DEPTH (words, power of two), NOP_WORD
// (returned on faulted fetch).
// Optional feature: define INSMEM_PARITY_EN to store an even-parity bit per
// word and report mismatches on resp_perr; otherwise resp_perr is tied to 0.
// ----------------------------------------------------------------------------
module instr_fetch_mem
    import insmem_pkg::*;
#(
    parameter int              WIDTH    = 32,
    parameter int              DEPTH    = 64,
    parameter logic [WIDTH-1:0] NOP_WORD = WIDTH'(NOP_WORD_DEFAULT)
) (
    input  logic                    clk,
    input  logic                    reset,
    instr_fetch_mem_if.slave        bus,
    output insmem_state_e           dbg_state
);

    localparam int ADDR_W = $clog2(DEPTH);
`ifdef INSMEM_PARITY_EN
    localparam int MEM_W  = WIDTH + 1;
`else
    localparam int MEM_W  = WIDTH;
`endif

    insmem_state_e     state_q;
    insmem_state_e     state_d;
    logic              loaded;
    logic              ld_we;

    logic              resp_valid_q;
    logic              resp_valid_d;
    logic              resp_fault_q;
    logic              resp_fault_d;

    logic              req_ready;
    logic              accept;
    logic              pc_fault;
    logic [31:0]       word_idx;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  rd_word;
    logic              perr;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state (RUN is terminal) ----------------
    always_comb begin
        state_d = state_q;
        if (state_q == LOAD && bus.ld_valid && bus.ld_last) begin
            state_d = RUN;
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        loaded = (state_q == RUN);
        ld_we  = (state_q == LOAD) && bus.ld_valid;
    end

    // ---------------- Request side ----------------
    always_comb begin
        word_idx  = bus.req_pc >> 2;
        pc_fault  = (bus.req_pc[1:0] != 2'b00) || (word_idx >= 32'(DEPTH));
        rd_addr   = bus.req_pc[ADDR_W+1:2];
        // A new request may enter only when the response slot is free or
        // being drained this cycle; flush blocks acceptance outright.
        req_ready = loaded && (!resp_valid_q || bus.resp_ready) && !bus.flush;
        accept    = bus.req_valid && req_ready;
        // Faulted fetches skip the read so the array is never indexed out of range.
        rd_en     = accept && !pc_fault;
    end

    // ---------------- Response slot ----------------
    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_fault_d = resp_fault_q;
        if (bus.flush) begin
            resp_valid_d = 1'b0;
        end else if (accept) begin
            resp_valid_d = 1'b1;
            resp_fault_d = pc_fault;
        end else if (bus.resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    // ---------------- Storage ----------------
`ifdef INSMEM_PARITY_EN
    // Stored bit makes the word plus parity carry an even number of ones.
    assign wr_word = {^bus.ld_data, bus.ld_data};
    assign perr    = !resp_fault_q && ((^rd_word[WIDTH-1:0]) != rd_word[WIDTH]);
`else
    assign wr_word = bus.ld_data;
    assign perr    = 1'b0;
`endif

    insmem_array #(
        .WIDTH (MEM_W),
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .rst   (reset),
        .we    (ld_we),
        .waddr (bus.ld_addr),
        .wdata (wr_word),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_word)
    );

    // ---------------- Outputs ----------------
    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_fault = resp_fault_q;
    assign bus.resp_instr = resp_fault_q ? NOP_WORD : rd_word[WIDTH-1:0];
    assign bus.resp_perr  = perr;
    assign bus.loaded     = loaded;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
module tb_instr_fetch_mem;
    import insmem_pkg::*;

    localparam int          WIDTH = 32;
    localparam int          DEPTH = 64;
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [31:0] NOP   = 32'h0000_0000;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset;
    insmem_state_e dbg_state;

    always #5 clk = ~clk;

    instr_fetch_mem_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    instr_fetch_mem #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .NOP_WORD (NOP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] mem_m [DEPTH];
    logic [32:0] exp_q [$];      // {fault, instr} of the outstanding response

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: what a fetch of byte address pc must return.
    function automatic void model(input logic [31:0] pc, output logic [31:0] ei, output logic ef);
        ef = (pc % 4 != 0) || (pc / 4 >= DEPTH);
        if (ef) ei = NOP;
        else    ei = mem_m[pc / 4];
    endfunction

    task automatic check_idle_reset(input string tag);
        check({tag, ":loaded"},     64'(bus.loaded),     64'd0);
        check({tag, ":resp_valid"}, 64'(bus.resp_valid), 64'd0);
        check({tag, ":resp_instr"}, 64'(bus.resp_instr), 64'd0);
        check({tag, ":resp_fault"}, 64'(bus.resp_fault), 64'd0);
        check({tag, ":resp_perr"},  64'(bus.resp_perr),  64'd0);
        check({tag, ":req_ready"},  64'(bus.req_ready),  64'd0);
        check({tag, ":state"},      64'(dbg_state),      64'(LOAD));
    endtask

    task automatic load_word(input int addr, input logic [31:0] data, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = AW'(addr);
        bus.ld_data  = data;
        bus.ld_last  = last;
        mem_m[addr]  = data;
        @(negedge clk);
        check("load:loaded_low", 64'(bus.loaded), 64'd0);
        tick();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    // One fetch with resp_ready held high; response checked one cycle later.
    task automatic fetch_one(input string tag, input logic [31:0] pc, input logic exp_perr);
        logic [31:0] ei;
        logic        ef;
        model(pc, ei, ef);
        bus.req_valid  = 1'b1;
        bus.req_pc     = pc;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check({tag, ":req_ready"}, 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_valid = 1'b0;
        @(negedge clk);
        check({tag, ":resp_valid"}, 64'(bus.resp_valid), 64'd1);
        check({tag, ":resp_instr"}, 64'(bus.resp_instr), 64'(ei));
        check({tag, ":resp_fault"}, 64'(bus.resp_fault), 64'(ef));
        check({tag, ":resp_perr"},  64'(bus.resp_perr),  64'(exp_perr));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ei;
        logic        ef;
        logic        rv, rr, fl, exp_ready;
        logic [31:0] pc;
        int          sel;

        bus.ld_valid   = 1'b0;
        bus.ld_addr    = '0;
        bus.ld_data    = '0;
        bus.ld_last    = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_pc     = '0;
        bus.flush      = 1'b0;
        bus.resp_ready = 1'b0;
        reset          = 1'b1;

        // ---- reset state, with a request pending that must be ignored ----
        repeat (2) @(posedge clk);
        #1;
        bus.req_valid  = 1'b1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check_idle_reset("reset");
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        tick();

        // ---- load four words, ld_last on the fourth ----
        for (int i = 0; i < 4; i++) begin
            load_word(i, 32'h1111_1111 * (i + 1), (i == 3));
        end
        @(negedge clk);
        check("load:loaded_high", 64'(bus.loaded), 64'd1);
        check("load:state_run",   64'(dbg_state),  64'(RUN));
        check("load:resp_idle",   64'(bus.resp_valid), 64'd0);

        // Loader writes in RUN are ignored.
        tick();
        bus.ld_valid = 1'b1;
        bus.ld_addr  = AW'(2);
        bus.ld_data  = 32'hDEAD_BEEF;
        tick();
        bus.ld_valid = 1'b0;

        // ---- basic fetches and fault cases ----
        fetch_one("pc08", 32'h0000_0008, 1'b0);
        fetch_one("pc06_misaligned", 32'h0000_0006, 1'b0);
        fetch_one("pc100_range", 32'h0000_0100, 1'b0);
        fetch_one("pc0c", 32'h0000_000C, 1'b0);

        // ---- stall for 3 cycles, then back-to-back fetches 0x0, 0x4 ----
        bus.req_valid  = 1'b1;
        bus.req_pc     = 32'h4;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        check("stall:first_ready", 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall:req_ready",  64'(bus.req_ready),  64'd0);
            check("stall:resp_valid", 64'(bus.resp_valid), 64'd1);
            check("stall:resp_instr", 64'(bus.resp_instr), 64'h2222_2222);
            check("stall:resp_fault", 64'(bus.resp_fault), 64'd0);
            tick();
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("b2b:ready0", 64'(bus.req_ready),  64'd1);
        check("b2b:held",   64'(bus.resp_instr), 64'h2222_2222);
        tick();
        bus.req_pc = 32'h4;
        @(negedge clk);
        check("b2b:ready4",  64'(bus.req_ready),  64'd1);
        check("b2b:valid0",  64'(bus.resp_valid), 64'd1);
        check("b2b:instr0",  64'(bus.resp_instr), 64'h1111_1111);
        tick();
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("b2b:valid4", 64'(bus.resp_valid), 64'd1);
        check("b2b:instr4", 64'(bus.resp_instr), 64'h2222_2222);
        tick();
        @(negedge clk);
        check("b2b:drained", 64'(bus.resp_valid), 64'd0);
        tick();

        // ---- flush while a response is held ----
        bus.req_valid  = 1'b1;
        bus.req_pc     = 32'h8;
        bus.resp_ready = 1'b0;
        tick();
        bus.flush      = 1'b1;
        bus.req_pc     = 32'hC;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("flush:req_ready",  64'(bus.req_ready),  64'd0);
        check("flush:resp_valid", 64'(bus.resp_valid), 64'd1);
        tick();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("flush:cleared", 64'(bus.resp_valid), 64'd0);
        tick();
        @(negedge clk);
        check("flush:no_accept", 64'(bus.resp_valid), 64'd0);
        tick();

        // ---- parity ----
`ifdef INSMEM_PARITY_EN
        dut.u_array.mem[2][0] = ~dut.u_array.mem[2][0];
        mem_m[2] = mem_m[2] ^ 32'h1;
        fetch_one("perr_flip", 32'h8, 1'b1);
        dut.u_array.mem[2][0] = ~dut.u_array.mem[2][0];
        mem_m[2] = mem_m[2] ^ 32'h1;
        fetch_one("perr_clean", 32'h8, 1'b0);
`else
        fetch_one("perr_off", 32'h8, 1'b0);
`endif

        // ---- randomized traffic against the outstanding-response queue ----
        exp_q.delete();
        for (int cyc = 0; cyc < 300; cyc++) begin
            rv  = 1'($urandom_range(0, 1));
            rr  = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 11) == 0);
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       pc = 32'($urandom_range(0, 3)) << 2;
            else if (sel == 7) pc = (32'($urandom_range(0, 3)) << 2) + 32'($urandom_range(1, 3));
            else if (sel == 8) pc = 32'h100 + (32'($urandom_range(0, 1000)) << 2);
            else               pc = $urandom() | 32'h8000_0000;
            bus.req_valid  = rv;
            bus.req_pc     = pc;
            bus.resp_ready = rr;
            bus.flush      = fl;
            @(negedge clk);
            exp_ready = (exp_q.size() == 0 || rr) && !fl;
            check("rand:req_ready", 64'(bus.req_ready), 64'(exp_ready));
            if (exp_q.size() != 0) begin
                check("rand:resp_valid", 64'(bus.resp_valid), 64'd1);
                check("rand:resp_instr", 64'(bus.resp_instr), 64'(exp_q[0][31:0]));
                check("rand:resp_fault", 64'(bus.resp_fault), 64'(exp_q[0][32]));
                check("rand:resp_perr",  64'(bus.resp_perr),  64'd0);
            end else begin
                check("rand:resp_idle", 64'(bus.resp_valid), 64'd0);
            end
            if (fl) begin
                exp_q.delete();
            end else begin
                if (rr && exp_q.size() != 0) void'(exp_q.pop_front());
                if (rv && exp_ready) begin
                    model(pc, ei, ef);
                    exp_q.push_back({ef, ei});
                end
            end
            tick();
        end
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;

        // ---- reset in the middle of a load ----
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick();
        load_word(4, $urandom(), 1'b0);
        load_word(5, $urandom(), 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_idle_reset("midload");
        reset          = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_pc     = 32'h0;
        bus.resp_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midload:req_ready",  64'(bus.req_ready),  64'd0);
            check("midload:resp_valid", 64'(bus.resp_valid), 64'd0);
            check("midload:loaded",     64'(bus.loaded),     64'd0);
            tick();
        end
        bus.req_valid = 1'b0;
        load_word(6, 32'h6666_6666, 1'b1);
        @(negedge clk);
        check("midload:loaded_high", 64'(bus.loaded), 64'd1);
        tick();
        fetch_one("retained4", 32'h10, 1'b0);
        fetch_one("retained5", 32'h14, 1'b0);
        fetch_one("retained0", 32'h00, 1'b0);
        fetch_one("new6",      32'h18, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 SHALL have parameter WIDTH, default 32, instruction word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, number of words (power of two, 16..1024).
REQ-003 SHALL have parameter NOP_WORD, default all-zero, word returned on fault.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port ld_valid  input  1  loader write strobe.
REQ-007 SHALL have port ld_addr  input  clog2(DEPTH)  loader word index.
REQ-008 SHALL have port ld_data  input  WIDTH  loader word.
REQ-009 SHALL have port ld_last  input  1  marks final loader write.
REQ-010 SHALL have port req_valid  input  1  fetch request.
REQ-011 SHALL have port req_pc  input  32  byte address of fetch.
REQ-012 SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-013 SHALL have port flush  input  1  discard pending response.
REQ-014 SHALL have port resp_valid  output  1  response held.
REQ-015 SHALL have port resp_ready  input  1  consumer accepts response.
REQ-016 SHALL have port resp_instr  output  WIDTH  fetched word.
REQ-017 SHALL have port resp_fault  output  1  misaligned or out-of-range fetch.
REQ-018 SHALL have port resp_perr  output  1  parity error on fetched word.
REQ-019 SHALL have port loaded  output  1  high in RUN state.

Function
REQ-020 SHALL implement states LOAD and RUN; LOAD -> RUN on cycle ld_valid && ld_last; RUN is terminal until reset.
REQ-021 SHALL write mem[ld_addr] <= ld_data on ld_valid only in LOAD; ld_valid in RUN ignored.
REQ-022 SHALL drive req_ready = RUN && (!resp_valid || resp_ready) && !flush.
REQ-023 SHALL, on accept at cycle N, present resp_valid=1 with resp_instr = mem[req_pc[ADDR_W+1:2]] at cycle N+1 (latency 1, full throughput).
REQ-024 SHALL set resp_fault=1 and resp_instr=NOP_WORD when req_pc[1:0]!=0 or req_pc>>2 >= DEPTH.
REQ-025 SHALL hold resp_valid, resp_instr, resp_fault, resp_perr stable while resp_valid && !resp_ready.
REQ-026 SHALL clear resp_valid when resp_ready and no new accept in same cycle; accept+consume same cycle replaces response.
REQ-027 SHALL on flush clear resp_valid next cycle and accept no request that cycle; flush has priority over resp_ready.
REQ-028 SHALL keep resp_valid=0 throughout LOAD.

Reset
REQ-029 SHALL on reset force state LOAD, loaded=0, resp_valid=0, resp_instr=0, resp_fault=0, resp_perr=0, req_ready=0.
REQ-030 SHALL NOT clear memory contents on reset; reset mid-LOAD restarts load, previously written words retained.

Configuration
REQ-031 SHALL, with INSMEM_PARITY_EN defined, store one even-parity bit per word at load and set resp_perr when stored parity mismatches on read (not on faulted fetches).
REQ-032 SHALL, without INSMEM_PARITY_EN, store no parity bit and tie resp_perr to 0.

Structure
REQ-033 SHALL place state enum (LOAD, RUN) and default NOP_WORD in shared package insmem_pkg.
REQ-034 SHALL isolate storage in one sub-module insmem_array (sync write, sync read, WIDTH/DEPTH parameters).

Verification
REQ-035 SHALL test load 4 words (0x11111111..0x44444444, ld_last on 4th), loaded=1 next cycle; fetch pc 0x8 -> resp_instr 0x33333333 one cycle after accept.
REQ-036 SHALL test req_pc 0x6 -> resp_fault=1, resp_instr=NOP_WORD; req_pc 0x100 with DEPTH=64 -> resp_fault=1.
REQ-037 SHALL test resp_ready=0 for 3 cycles after response -> req_ready=0, outputs stable, then resp_ready=1 back-to-back fetches 0x0,0x4 delivered in order.
REQ-038 SHALL test flush while resp_valid=1 and resp_ready=0 -> resp_valid=0 next cycle, no request accepted in flush cycle.
REQ-039 SHALL test reset asserted mid-LOAD after 2 writes -> all outputs 0, state LOAD, req_valid ignored until new ld_last.
REQ-040 SHALL test with INSMEM_PARITY_EN, forced bit flip in stored word 2 -> resp_perr=1 on fetch pc 0x8; without macro resp_perr=0.
